// File: rtl/mode_pkg.sv
// -----------------------------------------------------------------------------
// mode_pkg
// Shared definitions for the mode selector and the mode LED display:
//   - 3-bit mode encodings MODE_DEFAULT..MODE_SETUP
//   - NUM_MODES (width of the mode switch bank)
//   - decode_sw(): maps the raw switch bank to a mode code plus a valid flag
// -----------------------------------------------------------------------------
package mode_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_DEFAULT = 3'd0;
    localparam mode_t MODE_STORE   = 3'd1;
    localparam mode_t MODE_GEN     = 3'd2;
    localparam mode_t MODE_SHOW    = 3'd3;
    localparam mode_t MODE_CALC    = 3'd4;
    localparam mode_t MODE_SETUP   = 3'd5;

    localparam int NUM_MODES = 5;

    typedef struct packed {
        logic  valid;   // exactly one switch set
        mode_t mode;    // bit index + 1 when valid, MODE_DEFAULT otherwise
    } sw_decode_t;

    // Switch bit i selects mode i+1. Anything other than exactly one set bit
    // is an invalid selection and decodes to MODE_DEFAULT.
    function automatic sw_decode_t decode_sw(input logic [NUM_MODES-1:0] sw);
        sw_decode_t d;
        int         ones;
        d.valid = 1'b0;
        d.mode  = MODE_DEFAULT;
        ones    = 0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (sw[i]) begin
                ones++;
                d.mode = mode_t'(i + 1);
            end
        end
        d.valid = (ones == 1);
        if (!d.valid) begin
            d.mode = MODE_DEFAULT;
        end
        return d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchroniser + debouncer + rising-edge pulse for one raw push button.
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles before a level change is
//                     accepted (>= 2)
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous, active-high reset
//   i_btn   - raw button level, asynchronous to i_clk
//   o_pulse - one-cycle pulse on an accepted press
// Latency: o_pulse is high in the cycle following edge DEBOUNCE_CYCLES+2,
// counting the first edge that samples the raw high as edge 0.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;      // [1] is the metastability-safe level
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_pulse;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            // Any return to the stable level restarts the count, so only an
            // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
            if (r_sync[1] != r_stable) begin
                if (r_cnt == CNT_MAX) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_stable_d <= r_stable;
            // Registered so the consumer sees a clean, glitch-free strobe.
            r_pulse    <= r_stable & ~r_stable_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/mode_select_ctrl.sv
// -----------------------------------------------------------------------------
// mode_select_ctrl
// Top-level mode state machine. Turns the raw mode switches and the confirm /
// back push buttons into the current mode, an error flag and a blink phase.
// Parameters:
//   DEBOUNCE_CYCLES - button debounce length in cycles (>= 2)
//   BLINK_HALF      - cycles per blink_bit half-period while in error (>= 2)
//   ERR_CYCLES      - error display duration (only with ERROR_TIMEOUT_EN)
// Ports:
//   clk          - system clock
//   rst          - synchronous, active-high reset
//   mode_sw      - raw switches: bit0 STORE .. bit4 SETUP
//   confirm_btn  - raw confirm button (async, active-high)
//   back_btn     - raw back button (async, active-high)
//   mode_state   - 0 DEFAULT, 1 STORE, 2 GEN, 3 SHOW, 4 CALC, 5 SETUP
//   error_active - high while an invalid selection is being signalled
//   blink_bit    - blink phase, 0 whenever error_active is 0
// Build option:
//   ERROR_TIMEOUT_EN - when defined, the error clears itself after ERR_CYCLES.
// -----------------------------------------------------------------------------
module mode_select_ctrl
    import mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int BLINK_HALF      = 12500000,
    parameter int ERR_CYCLES      = 100000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_MODES-1:0] mode_sw,
    input  logic                 confirm_btn,
    input  logic                 back_btn,
    output logic [2:0]           mode_state,
    output logic                 error_active,
    output logic                 blink_bit
);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("mode_select_ctrl: DEBOUNCE_CYCLES must be >= 2");
    end
    if (BLINK_HALF < 2) begin : g_bad_blink
        $error("mode_select_ctrl: BLINK_HALF must be >= 2");
    end
    if (ERR_CYCLES < 1) begin : g_bad_err
        $error("mode_select_ctrl: ERR_CYCLES must be >= 1");
    end

    localparam logic [1:0] ST_DEFAULT = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_ERROR   = 2'd2;

    localparam int            BW        = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic       w_confirm;
    logic       w_back;
    sw_decode_t w_dec;
    logic       w_err_entry;
    logic       w_timeout;

    logic [1:0]    r_state;
    mode_t         r_mode;
    logic          r_err;
    logic          r_blink;
    logic [BW-1:0] r_blink_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm_db (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_btn   (confirm_btn),
        .o_pulse (w_confirm)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_btn   (back_btn),
        .o_pulse (w_back)
    );

    assign w_dec = decode_sw(mode_sw);

    // An invalid confirm outside ACTIVE (re)starts the error; back has priority.
    assign w_err_entry = w_confirm & ~w_back & (r_state != ST_ACTIVE) & ~w_dec.valid;

`ifdef ERROR_TIMEOUT_EN
    localparam int            TW      = $clog2(ERR_CYCLES + 1);
    localparam logic [TW-1:0] TMR_MAX = TW'(ERR_CYCLES - 1);

    logic [TW-1:0] r_err_tmr;

    always_ff @(posedge clk) begin
        if (rst || w_err_entry) begin
            r_err_tmr <= '0;
        end else if (r_state == ST_ERROR) begin
            r_err_tmr <= r_err_tmr + TW'(1);
        end else begin
            r_err_tmr <= '0;
        end
    end

    // Fires on the edge that lands ERR_CYCLES cycles after error entry.
    assign w_timeout = (r_state == ST_ERROR) && (r_err_tmr == TMR_MAX);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_DEFAULT;
            r_mode      <= MODE_DEFAULT;
            r_err       <= 1'b0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_back) begin
            // Back leaves ACTIVE or ERROR; in plain DEFAULT it is a no-op,
            // and it always masks a coincident confirm.
            if (r_state != ST_DEFAULT) begin
                r_state     <= ST_DEFAULT;
                r_mode      <= MODE_DEFAULT;
                r_err       <= 1'b0;
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end
        end else if (w_confirm && (r_state != ST_ACTIVE)) begin
            if (w_dec.valid) begin
                r_state <= ST_ACTIVE;
                r_mode  <= w_dec.mode;
                r_err   <= 1'b0;
                r_blink <= 1'b0;
            end else begin
                r_state <= ST_ERROR;
                r_mode  <= MODE_DEFAULT;
                r_err   <= 1'b1;
                r_blink <= 1'b1;
            end
            r_blink_cnt <= '0;
        end else if (r_state == ST_ERROR) begin
            if (w_timeout) begin
                r_state     <= ST_DEFAULT;
                r_err       <= 1'b0;
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == BLINK_MAX) begin
                // First toggle lands BLINK_HALF edges after entry.
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign mode_state   = r_mode;
    assign error_active = r_err;
    assign blink_bit    = r_blink;

endmodule

// File: tb/tb_mode_select_ctrl.sv
module tb_mode_select_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] mode_sw;
    logic       confirm_btn;
    logic       back_btn;
    logic [2:0] mode_state;
    logic       error_active;
    logic       blink_bit;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mode_select_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_HALF      (8),
        .ERR_CYCLES      (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_sw      (mode_sw),
        .confirm_btn  (confirm_btn),
        .back_btn     (back_btn),
        .mode_state   (mode_state),
        .error_active (error_active),
        .blink_bit    (blink_bit)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_confirm();
        confirm_btn = 1'b1;
        cyc(10);
        confirm_btn = 1'b0;
        cyc(10);
    endtask

    task automatic press_back();
        back_btn = 1'b1;
        cyc(10);
        back_btn = 1'b0;
        cyc(10);
    endtask

    initial begin
        rst         = 1'b1;
        mode_sw     = 5'b00000;
        confirm_btn = 1'b0;
        back_btn    = 1'b0;
        cyc(3);
        chk("rst_mode",  mode_state,   0);
        chk("rst_err",   error_active, 0);
        chk("rst_blink", blink_bit,    0);
        rst = 1'b0;
        cyc(2);

        // 1: valid selection, mode appears 7 edges after the first sample
        mode_sw     = 5'b00100;
        confirm_btn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("t1_mode_wait", mode_state,   0);
            chk("t1_err_wait",  error_active, 0);
        end
        cyc(1);
        chk("t1_mode_show", mode_state,   3);
        chk("t1_err",       error_active, 0);
        chk("t1_blink",     blink_bit,    0);
        cyc(2);
        confirm_btn = 1'b0;
        cyc(10);

        // 2: ACTIVE ignores switch change + confirm; back returns to DEFAULT
        mode_sw = 5'b00001;
        press_confirm();
        chk("t2_mode_hold", mode_state, 3);
        back_btn = 1'b1;
        cyc(7);
        chk("t2_back_wait", mode_state, 3);
        cyc(1);
        chk("t2_back_mode", mode_state,   0);
        chk("t2_back_err",  error_active, 0);
        back_btn = 1'b0;
        cyc(10);

        // 3: two bits set -> error with blink
        mode_sw     = 5'b00110;
        confirm_btn = 1'b1;
        cyc(7);
        chk("t3_err_wait", error_active, 0);
        cyc(1);                                  // entry edge
        chk("t3_err",   error_active, 1);
        chk("t3_blink", blink_bit,    1);
        chk("t3_mode",  mode_state,   0);
        cyc(2);
        confirm_btn = 1'b0;
        cyc(5);                                  // entry+7
        chk("t3_blink_e7", blink_bit, 1);
        cyc(1);                                  // entry+8
        chk("t3_blink_e8", blink_bit, 0);
        cyc(8);                                  // entry+16
        chk("t3_blink_e16", blink_bit, 1);
        cyc(47);                                 // entry+63
        chk("t3_err_e63", error_active, 1);
        cyc(1);                                  // entry+64
        chk("t3_mode_e64", mode_state, 0);
`ifdef ERROR_TIMEOUT_EN
        chk("t3_timeout_err",   error_active, 0);
        chk("t3_timeout_blink", blink_bit,    0);
        press_confirm();                         // re-enter error for step 4
        chk("t3_reenter_err", error_active, 1);
`else
        chk("t3_err_e64", error_active, 1);
        cyc(136);                                // entry+200, 25 toggles
        chk("t3_err_e200",   error_active, 1);
        chk("t3_blink_e200", blink_bit,    0);
`endif

        // 4: valid confirm from ERROR
        mode_sw     = 5'b10000;
        confirm_btn = 1'b1;
        cyc(7);
        chk("t4_err_wait",  error_active, 1);
        chk("t4_mode_wait", mode_state,   0);
        cyc(1);
        chk("t4_mode",  mode_state,   5);
        chk("t4_err",   error_active, 0);
        chk("t4_blink", blink_bit,    0);
        cyc(2);
        confirm_btn = 1'b0;
        cyc(10);

        // 5: short glitch ignored; coincident back beats confirm
        press_back();
        chk("t5_back_mode", mode_state, 0);
        mode_sw     = 5'b00010;
        confirm_btn = 1'b1;
        cyc(3);
        confirm_btn = 1'b0;
        cyc(15);
        chk("t5_glitch_mode", mode_state,   0);
        chk("t5_glitch_err",  error_active, 0);
        mode_sw = 5'b00110;
        press_confirm();
        chk("t5_err_entry", error_active, 1);
        mode_sw     = 5'b00010;
        confirm_btn = 1'b1;
        back_btn    = 1'b1;
        cyc(10);
        confirm_btn = 1'b0;
        back_btn    = 1'b0;
        cyc(10);
        chk("t5_both_mode",  mode_state,   0);
        chk("t5_both_err",   error_active, 0);
        chk("t5_both_blink", blink_bit,    0);

        // 6: reset mid-error, then all-zero switches is an error
        mode_sw     = 5'b00110;
        confirm_btn = 1'b1;
        cyc(8);
        chk("t6_err",   error_active, 1);
        chk("t6_blink", blink_bit,    1);
        rst         = 1'b1;
        confirm_btn = 1'b0;
        cyc(1);
        chk("t6_rst_mode",  mode_state,   0);
        chk("t6_rst_err",   error_active, 0);
        chk("t6_rst_blink", blink_bit,    0);
        rst = 1'b0;
        cyc(2);
        mode_sw = 5'b00000;
        press_confirm();
        chk("t6_zero_err",  error_active, 1);
        chk("t6_zero_mode", mode_state,   0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
